// File: rtl/dstack_ctl.sv
// dstack_ctl: command front-end for the stack2pipe4 data stack.
// Keeps top-of-stack (T) in a local register, presents N straight from the
// stack read port, tracks occupancy and rejects ops that would over/underflow.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_valid/cmd_op/cmd_data must stay stable while
// cmd_valid is high and cmd_ready is low. cmd_ready is low only during the
// second cycle of DROP2. A rejected command is still consumed.
module dstack_ctl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [WIDTH-1:0]              cmd_data,
  output logic [WIDTH-1:0]              tos,
  output logic [WIDTH-1:0]              nos,
  output logic [$clog2(DEPTH+2)-1:0]    depth,
  output logic                          err_ovf,
  output logic                          err_unf,
  output logic                          st_we,
  output logic [WIDTH-1:0]              st_wd,
  output logic [1:0]                    st_delta,
  input  logic [WIDTH-1:0]              st_rd
);

  localparam int DW = $clog2(DEPTH+2);

  // Total capacity counts T as one item on top of the DEPTH stack entries.
  localparam logic [DW-1:0] CAP  = DW'(DEPTH + 1);
  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] TWO  = DW'(2);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_DROP  = 3'd2;
  localparam logic [2:0] OP_SWAP  = 3'd3;
  localparam logic [2:0] OP_DUP   = 3'd4;
  localparam logic [2:0] OP_OVER  = 3'd5;
  localparam logic [2:0] OP_DROP2 = 3'd6;

  // Stack delta encoding: [0]=move, [1]=pop.
  localparam logic [1:0] D_FREEZE = 2'b00;
  localparam logic [1:0] D_PUSH   = 2'b01;
  localparam logic [1:0] D_POP    = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    DROP2B = 1'b1
  } state_t;

  // State is kept in a named enum signal so checkers can bind to it directly.
  state_t state, state_n;

  logic [WIDTH-1:0] tos_n;
  logic [DW-1:0]    depth_n;
  logic             ovf_set;
  logic             unf_set;
  logic             drop_act;
  logic             accept;
  logic             full;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign full      = (depth == CAP);
  assign nos       = st_rd;
  assign st_wd     = tos;

  // Register update: T, depth, sticky flags and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tos     <= '0;
      depth   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      state <= state_n;
      tos   <= tos_n;
      depth <= depth_n;
      if (ovf_set) err_ovf <= 1'b1;
      if (unf_set) err_unf <= 1'b1;
    end
  end

  // Decode the accepted op (or the DROP2 second half) into next T/depth and
  // stack controls. A drop is shared by DROP, both halves of DROP2.
  always_comb begin
    state_n  = state;
    tos_n    = tos;
    depth_n  = depth;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    drop_act = 1'b0;
    st_we    = 1'b0;
    st_delta = D_FREEZE;

    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_PUSH: begin
              if (full) begin
                ovf_set = 1'b1;
              end else begin
                tos_n   = cmd_data;
                depth_n = depth + ONE;
                // With nothing in T yet there is no old value to spill.
                if (depth != '0) begin
                  st_we    = 1'b1;
                  st_delta = D_PUSH;
                end
              end
            end
            OP_DROP: begin
              if (depth == '0) unf_set  = 1'b1;
              else             drop_act = 1'b1;
            end
            OP_SWAP: begin
              if (depth < TWO) begin
                unf_set = 1'b1;
              end else begin
                tos_n = st_rd;
                st_we = 1'b1;   // old T overwrites N in place
              end
            end
            OP_DUP: begin
              if (depth == '0) begin
                unf_set = 1'b1;
              end else if (full) begin
                ovf_set = 1'b1;
              end else begin
                st_we    = 1'b1;
                st_delta = D_PUSH;
                depth_n  = depth + ONE;
              end
            end
            OP_OVER: begin
              if (depth < TWO) begin
                unf_set = 1'b1;
              end else if (full) begin
                ovf_set = 1'b1;
              end else begin
                tos_n    = st_rd;
                st_we    = 1'b1;
                st_delta = D_PUSH;
                depth_n  = depth + ONE;
              end
            end
            OP_DROP2: begin
              if (depth < TWO) begin
                unf_set = 1'b1;
              end else begin
                drop_act = 1'b1;
                state_n  = DROP2B;
              end
            end
            default: begin
              // OP_NOP and unused encodings leave everything untouched.
            end
          endcase
        end
      end
      DROP2B: begin
        // Legality was checked on the first half, depth is at least 1 here.
        drop_act = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (drop_act) begin
      depth_n = depth - ONE;
      if (depth >= TWO) begin
        tos_n    = st_rd;
        st_delta = D_POP;
      end else begin
        tos_n = '0;
      end
    end
  end

endmodule

// File: tb/tb_dstack_ctl.sv
// tb_dstack_ctl: directed test of dstack_ctl against a behavioural stack
// model standing in for stack2pipe4.
module tb_dstack_ctl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH+2);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_DROP  = 3'd2;
  localparam logic [2:0] OP_SWAP  = 3'd3;
  localparam logic [2:0] OP_DUP   = 3'd4;
  localparam logic [2:0] OP_OVER  = 3'd5;
  localparam logic [2:0] OP_DROP2 = 3'd6;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [DW-1:0]    depth;
  logic             err_ovf;
  logic             err_unf;
  logic             st_we;
  logic [WIDTH-1:0] st_wd;
  logic [1:0]       st_delta;
  logic [WIDTH-1:0] st_rd;

  int n_checks;
  int n_errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dstack_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .tos       (tos),
    .nos       (nos),
    .depth     (depth),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf),
    .st_we     (st_we),
    .st_wd     (st_wd),
    .st_delta  (st_delta),
    .st_rd     (st_rd)
  );

  // ---------------- stack2pipe4 stand-in ----------------
  logic [WIDTH-1:0] mem [0:7];
  int               cnt;

  assign st_rd = (cnt > 0) ? mem[cnt-1] : '0;

  always @(posedge clk) begin
    if (reset) begin
      cnt <= 0;
    end else begin
      case (st_delta)
        2'b01: begin
          if (st_we && cnt < 8) mem[cnt] <= st_wd;
          cnt <= cnt + 1;
        end
        2'b11: if (cnt > 0) cnt <= cnt - 1;
        2'b00: if (st_we && cnt > 0) mem[cnt-1] <= st_wd;
        default: ;
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1 reset  = 1'b0;
  endtask

  // Present one command and hold it until it transfers; returns just after
  // the transferring edge.
  task automatic do_cmd(input logic [2:0] op, input logic [WIDTH-1:0] data);
    int waited;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    waited    = 0;
    while (!cmd_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 10) check("ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = '0;

    // T1: reset state, then three pushes
    do_reset();
    check("rst_tos",   32'(tos), 32'h0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_ovf",   32'(err_ovf), 32'd0);
    check("rst_unf",   32'(err_unf), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    do_cmd(OP_PUSH, 16'h0011);
    do_cmd(OP_PUSH, 16'h0022);
    // Third push with depth 2: old T must be spilled into the stack.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 16'h0033;
    #1;
    check("t1_st_we",    32'(st_we), 32'd1);
    check("t1_st_delta", 32'(st_delta), 32'b01);
    check("t1_st_wd",    32'(st_wd), 32'h0022);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("t1_tos",   32'(tos), 32'h0033);
    check("t1_nos",   32'(nos), 32'h0022);
    check("t1_depth", 32'(depth), 32'd3);
    check("t1_ovf",   32'(err_ovf), 32'd0);
    check("t1_unf",   32'(err_unf), 32'd0);

    // T2: fill to capacity, overflow, drain LIFO
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) do_cmd(OP_PUSH, 16'(16'h0010 + i));
    check("t2_full_depth", 32'(depth), 32'd5);
    check("t2_full_tos",   32'(tos), 32'h0014);
    do_cmd(OP_PUSH, 16'h0099);
    check("t2_ovf",       32'(err_ovf), 32'd1);
    check("t2_ovf_depth", 32'(depth), 32'd5);
    check("t2_ovf_tos",   32'(tos), 32'h0014);
    check("t2_ovf_nos",   32'(nos), 32'h0013);
    check("t2_ovf_unf",   32'(err_unf), 32'd0);
    for (int i = 4; i >= 0; i--) begin
      check($sformatf("t2_pop_tos%0d", i), 32'(tos), 32'(16'h0010 + i));
      do_cmd(OP_DROP, 16'h0);
    end
    check("t2_empty_depth", 32'(depth), 32'd0);
    check("t2_empty_tos",   32'(tos), 32'h0);

    // T3: drop on empty stack
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_DROP; cmd_data = '0;
    #1;
    check("t3_st_we",    32'(st_we), 32'd0);
    check("t3_st_delta", 32'(st_delta), 32'b00);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("t3_unf",   32'(err_unf), 32'd1);
    check("t3_ovf",   32'(err_ovf), 32'd0);
    check("t3_depth", 32'(depth), 32'd0);
    check("t3_tos",   32'(tos), 32'h0);

    // T4: SWAP, OVER, DUP
    do_reset();
    do_cmd(OP_PUSH, 16'h000A);
    do_cmd(OP_PUSH, 16'h000B);
    do_cmd(OP_SWAP, 16'h0);
    check("t4_swap_tos",   32'(tos), 32'h000A);
    check("t4_swap_nos",   32'(nos), 32'h000B);
    check("t4_swap_depth", 32'(depth), 32'd2);
    do_cmd(OP_OVER, 16'h0);
    check("t4_over_tos",   32'(tos), 32'h000B);
    check("t4_over_nos",   32'(nos), 32'h000A);
    check("t4_over_depth", 32'(depth), 32'd3);
    do_cmd(OP_DUP, 16'h0);
    check("t4_dup_tos",   32'(tos), 32'h000B);
    check("t4_dup_nos",   32'(nos), 32'h000B);
    check("t4_dup_depth", 32'(depth), 32'd4);
    check("t4_errs",      32'({err_ovf, err_unf}), 32'd0);

    // T5: DROP2 with a queued command held behind it
    do_reset();
    do_cmd(OP_PUSH, 16'h0001);
    do_cmd(OP_PUSH, 16'h0002);
    do_cmd(OP_PUSH, 16'h0003);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_DROP2; cmd_data = '0;
    check("t5_ready_pre", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check("t5_ready_busy", 32'(cmd_ready), 32'd0);
    check("t5_mid_tos",    32'(tos), 32'h0002);
    check("t5_mid_depth",  32'(depth), 32'd2);
    cmd_op = OP_PUSH; cmd_data = 16'h0055;
    @(negedge clk);
    check("t5_ready_back", 32'(cmd_ready), 32'd1);
    check("t5_tos",        32'(tos), 32'h0001);
    check("t5_depth",      32'(depth), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t5_q_tos",   32'(tos), 32'h0055);
    check("t5_q_nos",   32'(nos), 32'h0001);
    check("t5_q_depth", 32'(depth), 32'd2);

    // DROP2 with only one item is rejected
    do_cmd(OP_DROP, 16'h0);
    do_cmd(OP_DROP2, 16'h0);
    check("t5_d2_unf",   32'(err_unf), 32'd1);
    check("t5_d2_depth", 32'(depth), 32'd1);
    check("t5_d2_tos",   32'(tos), 32'h0001);
    check("t5_d2_ready", 32'(cmd_ready), 32'd1);

    // T6: reset while in the second half of DROP2
    do_reset();
    do_cmd(OP_DROP, 16'h0);
    check("t6_unf_set", 32'(err_unf), 32'd1);
    do_cmd(OP_PUSH, 16'h0001);
    do_cmd(OP_PUSH, 16'h0002);
    do_cmd(OP_PUSH, 16'h0003);
    do_cmd(OP_DROP2, 16'h0);
    check("t6_in_drop2b", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_depth", 32'(depth), 32'd0);
    check("t6_tos",   32'(tos), 32'h0);
    check("t6_ready", 32'(cmd_ready), 32'd1);
    check("t6_flags", 32'({err_ovf, err_unf}), 32'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
